// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RSP  = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   function automatic int starve_cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data ports. The data port has priority
// until fetch has waited through STARVE_LIMIT consecutive data grants.
module mem_arb_prio
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arb_en,
   input  logic if_req,
   input  logic dm_req,
   output logic if_win,
   output logic dm_win
);

   localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             starved;

   always_comb begin
      starved = (starve_cnt_q == CNT_MAX);
      dm_win  = arb_en & dm_req & ~(if_req & starved);
      if_win  = arb_en & if_req & ~dm_win;
   end

   // Counts only while fetch is actually waiting; any fetch win or idle fetch clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || if_win) begin
         starve_cnt_d = '0;
      end else if (dm_win && !starved) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port synchronous RAM. Writes complete in
// the grant cycle; reads occupy a response cycle and return rvalid two cycles after grant.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_adr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_adr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_rvalid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_adr,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  busy,
   output logic                  dbg_state
);

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic                  if_rvalid_q, if_rvalid_d;
   logic                  dm_rvalid_q, dm_rvalid_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

   logic                  arb_en, if_win, dm_win, gnt_any;
   logic [ADDR_WIDTH-1:0] win_adr;

   // Grants are suppressed while reset is held so outputs sit at their reset values.
   assign arb_en  = rst_n & (state_q == ST_IDLE);
   assign gnt_any = if_win | dm_win;
   assign win_adr = dm_win ? dm_adr : if_adr;

   mem_arb_prio #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_prio (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_en (arb_en),
      .if_req (if_req),
      .dm_req (dm_req),
      .if_win (if_win),
      .dm_win (dm_win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         adr_q       <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         adr_q       <= adr_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      adr_d       = adr_q;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               adr_d = win_adr;
               if (if_win || !dm_we) begin
                  state_d = ST_RSP;
                  owner_d = dm_win ? OWN_DM : OWN_IF;
               end
            end
         end
         ST_RSP: begin
            // The RAM presents the read word on the bus during the whole response cycle.
            state_d = ST_IDLE;
            if (owner_q == OWN_DM) begin
               dm_rvalid_d = 1'b1;
               dm_rdata_d  = ram_data;
            end else begin
               if_rvalid_d = 1'b1;
               if_rdata_d  = ram_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      if_gnt    = if_win;
      dm_gnt    = dm_win;
      ram_we    = dm_win & dm_we;
      ram_adr   = gnt_any ? win_adr : adr_q;
      busy      = (state_q == ST_RSP);
      dbg_state = logic'(state_q);
      if_rvalid = if_rvalid_q;
      dm_rvalid = dm_rvalid_q;
      if_rdata  = if_rdata_q;
      dm_rdata  = dm_rdata_q;
   end

   assign ram_data = ram_we ? dm_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grants, bus
// activity and read returns every cycle; directed cases pin the model with literal values.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 64;
   localparam int STARVE_LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_adr, dm_adr;
   logic [DW-1:0] dm_wdata;
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   logic [DW-1:0] if_rdata, dm_rdata;
   logic          ram_we, busy, dbg_state;
   logic [AW-1:0] ram_adr;
   wire  [DW-1:0] ram_data;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_adr    (if_adr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_adr    (dm_adr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .ram_we    (ram_we),
      .ram_adr   (ram_adr),
      .ram_data  (ram_data),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input int a);
      logic [DW-1:0] v;
      v = 64'hA5A5_0000_0000_0000 | DW'(a * 3 + 1);
      if (a == 16) v = 64'h0000_0000_DEAD_BEEF;
      return v;
   endfunction

   // ---------------- RAM environment (synchronous single port) ----------------
   logic [DW-1:0] ram_arr [0:255];
   logic [DW-1:0] ram_rd_q;

   always @(posedge clk) begin
      if (ram_we) ram_arr[ram_adr[7:0]] <= ram_data;
      else        ram_rd_q <= ram_arr[ram_adr[7:0]];
   end
   assign ram_data = ram_we ? {DW{1'bz}} : ram_rd_q;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      bit            to_dm;
      logic [DW-1:0] data;
   } rsp_t;

   logic [DW-1:0] ref_mem [0:255];
   rsp_t          rsp_q[$];
   bit            m_rsp;
   int            m_cnt;
   logic [AW-1:0] m_last_adr;
   logic [DW-1:0] e_if_rdata, e_dm_rdata;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_arr[i] <= init_val(i);
         ref_mem[i] = init_val(i);
      end
   end

   always @(negedge clk) begin : compare
      logic          e_ifg, e_dmg, e_we, e_ifrv, e_dmrv, any_req, dm_wins;
      logic [AW-1:0] e_adr;
      rsp_t          r;
      if (!rst_n) begin
         m_rsp = 1'b0;
         m_cnt = 0;
         m_last_adr = '0;
         rsp_q.delete();
         e_if_rdata = '0;
         e_dm_rdata = '0;
         chk("rst_if_gnt", if_gnt, 0);
         chk("rst_dm_gnt", dm_gnt, 0);
         chk("rst_if_rvalid", if_rvalid, 0);
         chk("rst_dm_rvalid", dm_rvalid, 0);
         chk("rst_if_rdata", if_rdata, 0);
         chk("rst_dm_rdata", dm_rdata, 0);
         chk("rst_ram_we", ram_we, 0);
         chk("rst_ram_adr", ram_adr, 0);
         chk("rst_busy", busy, 0);
      end else begin
         e_ifrv = 1'b0;
         e_dmrv = 1'b0;
         if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            if (r.to_dm) begin e_dmrv = 1'b1; e_dm_rdata = r.data; end
            else         begin e_ifrv = 1'b1; e_if_rdata = r.data; end
         end
         any_req = if_req | dm_req;
         dm_wins = dm_req && !(if_req && m_cnt == STARVE_LIMIT);
         e_ifg   = !m_rsp && any_req && !dm_wins;
         e_dmg   = !m_rsp && dm_wins;
         e_we    = e_dmg && dm_we;
         e_adr   = e_dmg ? dm_adr : (e_ifg ? if_adr : m_last_adr);

         chk("if_gnt", if_gnt, e_ifg);
         chk("dm_gnt", dm_gnt, e_dmg);
         chk("ram_we", ram_we, e_we);
         chk("ram_adr", ram_adr, e_adr);
         chk("busy", busy, m_rsp);
         chk("dbg_state", dbg_state, m_rsp);
         chk("if_rvalid", if_rvalid, e_ifrv);
         chk("dm_rvalid", dm_rvalid, e_dmrv);
         chk("if_rdata", if_rdata, e_if_rdata);
         chk("dm_rdata", dm_rdata, e_dm_rdata);
         if (e_we)  chk("ram_data_wr", ram_data, dm_wdata);
         if (m_rsp) chk("ram_data_rsp", ram_data, ref_mem[m_last_adr[7:0]]);

         if (m_rsp) begin
            m_rsp = 1'b0;
         end else if (e_ifg || e_dmg) begin
            m_last_adr = e_adr;
            if (e_we) begin
               ref_mem[e_adr[7:0]] = dm_wdata;
            end else begin
               r.due   = cyc + 2;
               r.to_dm = e_dmg;
               r.data  = ref_mem[e_adr[7:0]];
               rsp_q.push_back(r);
               m_rsp = 1'b1;
            end
         end
         if (!if_req || e_ifg) m_cnt = 0;
         else if (e_dmg && m_cnt < STARVE_LIMIT) m_cnt++;
      end
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic if_op(input logic [AW-1:0] a, output int gcyc);
      int n;
      n = 0;
      gcyc = -1;
      if_req = 1'b1;
      if_adr = a;
      while (gcyc < 0 && n < 64) begin
         @(negedge clk);
         if (if_gnt) gcyc = cyc;
         n++;
      end
      chk("if_gnt_wait", (gcyc >= 0), 1);
      @(posedge clk);
      #1;
      if_req = 1'b0;
   endtask

   task automatic dm_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int gcyc);
      int n;
      n = 0;
      gcyc = -1;
      dm_req = 1'b1;
      dm_we = we;
      dm_adr = a;
      dm_wdata = d;
      while (gcyc < 0 && n < 64) begin
         @(negedge clk);
         if (dm_gnt) gcyc = cyc;
         n++;
      end
      chk("dm_gnt_wait", (gcyc >= 0), 1);
      @(posedge clk);
      #1;
      dm_req = 1'b0;
   endtask

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   int gi, gd, g1, g2, rel_cyc;
   int gdv[6];

   initial begin
      rst_n = 1'b0;
      if_req = 1'b0; if_adr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_adr = '0; dm_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rel_cyc = cyc;

      // fetch read of a preset word, grant right after reset release
      if_op(16'h0010, gi);
      chk("t1_first_gnt_cycle", gi, rel_cyc);
      @(negedge clk);
      chk("t1_busy_g1", busy, 1);
      chk("t1_rvalid_g1", if_rvalid, 0);
      @(negedge clk);
      chk("t1_rvalid_g2", if_rvalid, 1);
      chk("t1_rdata", if_rdata, 64'hDEAD_BEEF);
      realign();

      // back-to-back data writes then read-back
      dm_op(1'b1, 16'h0020, 64'h1234, g1);
      dm_op(1'b1, 16'h0021, 64'h5678, g2);
      chk("t2_b2b_writes", g2 - g1, 1);
      dm_op(1'b0, 16'h0021, 64'h0, gd);
      @(negedge clk);
      @(negedge clk);
      chk("t2_dm_rvalid", dm_rvalid, 1);
      chk("t2_dm_rdata", dm_rdata, 64'h5678);
      realign();

      // simultaneous requests: data first, fetch next idle cycle
      fork
         if_op(16'h0022, gi);
         dm_op(1'b1, 16'h0023, 64'hAAAA, gd);
      join
      chk("t3_if_after_dm", gi - gd, 1);
      repeat (3) realign();

      // starvation: fetch waits through exactly STARVE_LIMIT data grants
      fork
         if_op(16'h0030, gi);
         for (int k = 0; k < 6; k++) dm_op(1'b1, AW'(16'h0040 + k), DW'(k + 100), gdv[k]);
      join
      chk("t4_if_after_4_dm", gi - gdv[0], 4);
      chk("t4_dm_run", gdv[3] - gdv[0], 3);
      chk("t4_dm_resume", gdv[4] - gi, 2);
      repeat (3) realign();

      // reset in the response cycle aborts the read
      if_op(16'h0010, gi);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_rvalid", if_rvalid, 0);
      chk("t5_rst_rdata", if_rdata, 64'h0);
      realign();
      realign();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_rvalid_after", if_rvalid, 0);
      realign();
      if_op(16'h0010, gi);
      @(negedge clk);
      @(negedge clk);
      chk("t5_read_rvalid", if_rvalid, 1);
      chk("t5_read_rdata", if_rdata, 64'hDEAD_BEEF);
      realign();

      // randomized traffic from both ports
      fork
         for (int k = 0; k < 250; k++) begin
            int gap, gc;
            gap = $urandom_range(0, 3);
            repeat (gap) realign();
            if_op(AW'($urandom_range(0, 63)), gc);
         end
         for (int k = 0; k < 250; k++) begin
            int gap, gc;
            gap = $urandom_range(0, 2);
            repeat (gap) realign();
            dm_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                  {$urandom, $urandom}, gc);
         end
      join
      repeat (4) realign();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
